// File: rtl/hydra_demo_pkg.sv
// Shared definitions for the 7-segment demo display path.
//  - disp_state_t: sequencer FSM encodings (FETCH -> SHOW -> WAIT).
//  - Default timing constants for the 50 MHz board.
//  - DEMO_PROGRAM: default ROM image, word i at bits [32*i +: 32].
package hydra_demo_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_SHOW  = 2'd1,
        ST_WAIT  = 2'd2
    } disp_state_t;

    // 1 s auto-advance and 20 ms debounce at 50 MHz.
    localparam int DEF_TICK_CYCLES     = 50_000_000;
    localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;

    localparam logic [127:0] DEMO_PROGRAM = {
        32'h0000006f,
        32'h002081b3,
        32'h00500113,
        32'h00c00193
    };

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer with press detection.
// Ports:
//  src_clk      in   system clock, rising edge
//  rst_n        in   synchronous active-low reset
//  key_n        in   raw active-low button, asynchronous and bouncing
//  press_pulse  out  one-cycle pulse when the debounced level goes 1 -> 0
// The raw key passes through a 2-FF synchronizer. The stable level only
// changes after DEBOUNCE_CYCLES consecutive cycles of disagreement with the
// synchronized sample; any agreeing cycle clears the counter. Releases are
// tracked but produce no pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic src_clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync_a;
    logic             sync_b;
    logic             stable;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             done;

    assign differ = (sync_b != stable);
    assign done   = differ && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            // Synchronizer resets to "released" so a key held through reset
            // is seen as a fresh press once reset is lifted.
            sync_a      <= 1'b1;
            sync_b      <= 1'b1;
            stable      <= 1'b1;
            cnt         <= '0;
            press_pulse <= 1'b0;
        end else begin
            sync_a      <= key_n;
            sync_b      <= sync_a;
            press_pulse <= 1'b0;
            if (!differ) begin
                cnt <= '0;
            end else if (done) begin
                cnt         <= '0;
                stable      <= sync_b;
                // Old level 1 means this change is a press (1 -> 0).
                press_pulse <= stable;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/instr_disp_sequencer.sv
// Instruction ROM sequencer feeding the 7-segment Digits decoder.
// Steps through a small ROM, presenting one 32-bit word at a time on disp.
// Advances on a debounced button press (manual) or a periodic tick (auto),
// wrapping to word 0 after the last word.
// Ports:
//  src_clk     in   system clock, rising edge
//  rst_n       in   synchronous active-low reset
//  key_step_n  in   raw active-low step button
//  sw_auto     in   1 = auto advance on tick, 0 = manual advance
//  disp        out  current instruction word (registered)
//  addr        out  ROM index of the word on disp
//  disp_valid  out  one-cycle pulse whenever disp is (re)loaded
// ROM contents come from ROM_INIT, word i at bits [32*i +: 32]; the read
// is registered so it maps onto block/distributed ROM.
module instr_disp_sequencer
    import hydra_demo_pkg::*;
#(
    parameter int                  DEPTH           = 16,
    parameter int                  ADDR_W          = $clog2(DEPTH),
    parameter int                  TICK_CYCLES     = DEF_TICK_CYCLES,
    parameter int                  DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [DEPTH*32-1:0] ROM_INIT        = (DEPTH*32)'(DEMO_PROGRAM)
) (
    input  logic              src_clk,
    input  logic              rst_n,
    input  logic              key_step_n,
    input  logic              sw_auto,
    output logic [31:0]       disp,
    output logic [ADDR_W-1:0] addr,
    output logic              disp_valid
);

    localparam int TICK_W = $clog2(TICK_CYCLES + 1);

    disp_state_t       state;
    disp_state_t       next_state;
    logic              fetch;
    logic              show;
    logic              advance;
    logic              step_pulse;
    logic              tick;
    logic              adv_event;
    logic [TICK_W-1:0] tick_cnt;
    logic [31:0]       rom_q;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .src_clk    (src_clk),
        .rst_n      (rst_n),
        .key_n      (key_step_n),
        .press_pulse(step_pulse)
    );

    // Tick counter runs only in auto mode; clearing it while manual makes
    // the first auto advance land a full period after sw_auto rises.
    always_ff @(posedge src_clk) begin
        if (!rst_n || !sw_auto) begin
            tick_cnt <= '0;
        end else if (tick_cnt == TICK_W'(TICK_CYCLES - 1)) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
        end
    end

    assign tick = sw_auto && (tick_cnt == TICK_W'(TICK_CYCLES - 1));

    // OR rather than add: a coincident press and tick is a single step.
    assign adv_event = step_pulse | tick;

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Events outside WAIT are ignored, so nothing queues up behind a fetch.
    always_comb begin
        next_state = state;
        fetch      = 1'b0;
        show       = 1'b0;
        advance    = 1'b0;
        case (state)
            ST_FETCH: begin
                fetch      = 1'b1;
                next_state = ST_SHOW;
            end
            ST_SHOW: begin
                show       = 1'b1;
                next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (adv_event) begin
                    advance    = 1'b1;
                    next_state = ST_FETCH;
                end
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase
    end

    always_ff @(posedge src_clk) begin
        if (!rst_n) begin
            rom_q      <= '0;
            disp       <= '0;
            addr       <= '0;
            disp_valid <= 1'b0;
        end else begin
            disp_valid <= show;
            if (fetch) begin
                rom_q <= ROM_INIT[{addr, 5'b00000} +: 32];
            end
            if (show) begin
                disp <= rom_q;
            end
            if (advance) begin
                addr <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_instr_disp_sequencer.sv
module tb_instr_disp_sequencer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;
    localparam logic [127:0] ROM_IMG = {
        32'h0000006f, 32'h002081b3, 32'h00500113, 32'h00c00193
    };

    logic              src_clk;
    logic              rst_n;
    logic              key_step_n;
    logic              sw_auto;
    logic [31:0]       disp;
    logic [ADDR_W-1:0] addr;
    logic              disp_valid;

    instr_disp_sequencer #(
        .DEPTH          (DEPTH),
        .ADDR_W         (ADDR_W),
        .TICK_CYCLES    (8),
        .DEBOUNCE_CYCLES(4),
        .ROM_INIT       (ROM_IMG)
    ) dut (
        .src_clk   (src_clk),
        .rst_n     (rst_n),
        .key_step_n(key_step_n),
        .sw_auto   (sw_auto),
        .disp      (disp),
        .addr      (addr),
        .disp_valid(disp_valid)
    );

    // clock / reset
    initial begin
        src_clk = 1'b0;
        forever #5 src_clk = ~src_clk;
    end

    typedef struct {
        string       name;
        logic        rst_n;
        logic        key_n;
        logic        sw_auto;
        int          cycles;
        logic [1:0]  exp_addr;
        logic [31:0] exp_disp;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   pulses   = 0;
    int   coincide = 0;

    function automatic vec_t mk(input string name, input logic r, input logic k,
                                input logic s, input int cyc, input logic [1:0] ea,
                                input logic [31:0] ed, input int ep);
        vec_t v;
        v.name = name; v.rst_n = r; v.key_n = k; v.sw_auto = s; v.cycles = cyc;
        v.exp_addr = ea; v.exp_disp = ed; v.exp_pulses = ep;
        return v;
    endfunction

    // driver: advance n clocks, sampling 1 time unit after each edge
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge src_clk);
            #1;
            if (disp_valid) pulses++;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    initial begin
        rst_n      = 1'b0;
        key_step_n = 1'b1;
        sw_auto    = 1'b0;

        //            name            rst key sw cyc addr disp          pulses
        vecs.push_back(mk("reset",      0, 1, 0, 3,  0, 32'h00000000, 0));
        vecs.push_back(mk("first_show", 1, 1, 0, 2,  0, 32'h00c00193, 1));
        vecs.push_back(mk("idle",       1, 1, 0, 4,  0, 32'h00c00193, 0));
        vecs.push_back(mk("glitch_lo",  1, 0, 0, 1,  0, 32'h00c00193, 0));
        vecs.push_back(mk("glitch_hi",  1, 1, 0, 1,  0, 32'h00c00193, 0));
        vecs.push_back(mk("press_hold", 1, 0, 0, 8,  1, 32'h00c00193, 0));
        vecs.push_back(mk("press_rel",  1, 1, 0, 10, 1, 32'h00500113, 1));
        vecs.push_back(mk("short_lo",   1, 0, 0, 3,  1, 32'h00500113, 0));
        vecs.push_back(mk("short_rel",  1, 1, 0, 10, 1, 32'h00500113, 0));
        vecs.push_back(mk("auto_a",     1, 1, 1, 10, 2, 32'h002081b3, 1));
        vecs.push_back(mk("auto_b",     1, 1, 1, 8,  3, 32'h0000006f, 1));
        vecs.push_back(mk("auto_wrap",  1, 1, 1, 8,  0, 32'h00c00193, 1));
        vecs.push_back(mk("auto_d",     1, 1, 1, 8,  1, 32'h00500113, 1));
        vecs.push_back(mk("manual_hold",1, 1, 0, 20, 1, 32'h00500113, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n      = vecs[i].rst_n;
            key_step_n = vecs[i].key_n;
            sw_auto    = vecs[i].sw_auto;
            pulses     = 0;
            run(vecs[i].cycles);
            check({vecs[i].name, ".addr"},   {30'b0, addr}, {30'b0, vecs[i].exp_addr});
            check({vecs[i].name, ".disp"},   disp, vecs[i].exp_disp);
            check({vecs[i].name, ".pulses"}, 32'(pulses), 32'(vecs[i].exp_pulses));
        end

        // press and tick land in the same WAIT cycle: single step 1 -> 2
        sw_auto = 1'b1;
        run(1);
        key_step_n = 1'b0;
        pulses   = 0;
        coincide = 0;
        for (int i = 0; i < 9; i++) begin
            run(1);
            if (dut.step_pulse && dut.tick) coincide++;
        end
        sw_auto    = 1'b0;
        key_step_n = 1'b1;
        run(12);
        check("same_cycle.coincide", 32'(coincide), 32'd1);
        check("same_cycle.addr", {30'b0, addr}, 32'd2);
        check("same_cycle.disp", disp, 32'h002081b3);
        check("same_cycle.pulses", 32'(pulses), 32'd1);

        // reset in the FETCH cycle right after an advance
        key_step_n = 1'b0;
        run(7);
        check("fetch_rst.pre_addr", {30'b0, addr}, 32'd3);
        rst_n      = 1'b0;
        key_step_n = 1'b1;
        pulses     = 0;
        run(1);
        check("fetch_rst.addr", {30'b0, addr}, 32'd0);
        check("fetch_rst.disp", disp, 32'h0);
        check("fetch_rst.valid", {31'b0, disp_valid}, 32'd0);
        run(1);
        rst_n  = 1'b1;
        pulses = 0;
        run(2);
        check("restart.disp", disp, 32'h00c00193);
        check("restart.addr", {30'b0, addr}, 32'd0);
        check("restart.pulses", 32'(pulses), 32'd1);
        pulses = 0;
        run(10);
        check("restart.quiet_addr", {30'b0, addr}, 32'd0);
        check("restart.quiet_pulses", 32'(pulses), 32'd0);

        // key held through reset: one press DEBOUNCE_CYCLES+2 after release
        key_step_n = 1'b0;
        rst_n      = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(6);
        check("held_rst.before", {30'b0, addr}, 32'd0);
        run(1);
        check("held_rst.after", {30'b0, addr}, 32'd1);
        run(2);
        check("held_rst.disp", disp, 32'h00500113);
        key_step_n = 1'b1;
        pulses     = 0;
        run(12);
        check("held_rst.single", {30'b0, addr}, 32'd1);
        check("held_rst.rel_pulses", 32'(pulses), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
